aes_spi_master: RTL

SPI master that drives one AES engine slave over a 4-wire link. It accepts a 128-bit block plus a 32·Nk-bit key on a start/done handshake, frames one chip-select transaction, and shifts out pad bits, block, key and gap bits. It then clocks the 128-bit result back in. It sits between the host-side control logic and the SPI_Slave-based encryption/decryption core, and is the only generator of that core's serial clock.

---
 rtl/aes_spi_pkg.sv | 35 +++
 rtl/aes_spi_clkgen.sv | 43 ++++
 rtl/aes_spi_master.sv | 135 +++++++++++++
 3 files changed

// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared types and frame-geometry helpers for the AES SPI master.
//   state_t      - master FSM states (IDLE, LEAD, SHIFT, GAP, RX, TRAIL)
//   BLOCK_W      - AES block width (128)
//   tx_bits      - number of bits shifted out (pads + block + key)
//   gap_end      - rise index of the last gap bit
//   rx_start     - number of rises before the first kept result bit
//   frame_bits   - total SCK cycles per frame (N)
//   cnt_width    - width needed to count 0..N rises
package aes_spi_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, RX, TRAIL} state_t;

  function automatic int tx_bits(int nk, int pad_bits);
    return pad_bits + BLOCK_W + 32 * nk;
  endfunction

  function automatic int gap_end(int nk, int pad_bits, int gap_bits);
    return tx_bits(nk, pad_bits) + gap_bits;
  endfunction

  function automatic int rx_start(int nk, int pad_bits, int gap_bits, int rx_skip);
    return gap_end(nk, pad_bits, gap_bits) + rx_skip;
  endfunction

  function automatic int frame_bits(int nk, int pad_bits, int gap_bits, int rx_skip);
    return rx_start(nk, pad_bits, gap_bits, rx_skip) + BLOCK_W;
  endfunction

  function automatic int cnt_width(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/aes_spi_clkgen.sv
// aes_spi_clkgen: SCK generator for the AES SPI master.
//   clk, rst (sync, active-low)
//   en        - run the divider (chip select asserted)
//   clr       - synchronous clear of divider and sck (frame abort)
//   hold      - keep ticking but do not toggle sck (trailing gap)
//   tick      - one strobe every CLK_DIV enabled cycles
//   rise_tick - tick that drives sck high
//   fall_tick - tick that drives sck low
//   sck       - serial clock, idles low
module aes_spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic hold,
  output logic tick,
  output logic rise_tick,
  output logic fall_tick,
  output logic sck
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;

  assign tick      = en && (div_cnt == DW'(CLK_DIV - 1));
  assign rise_tick = tick && !hold && !sck;
  assign fall_tick = tick && !hold && sck;

  always_ff @(posedge clk) begin
    if (!rst || clr || !en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else begin
      if (tick) div_cnt <= '0;
      else      div_cnt <= div_cnt + DW'(1);
      if (rise_tick || fall_tick) sck <= ~sck;
    end
  end

endmodule

// File: rtl/aes_spi_master.sv
// aes_spi_master: SPI master framing one AES block/key transfer and result read-back.
//   clk, rst (sync, active-low)
//   start, data_in[127:0], key_in[32*Nk-1:0] - request, latched when accepted in IDLE
//   busy, done, data_out[127:0]              - status and result (held until next done)
//   sck, cs_n, mosi, miso                    - 4-wire link to the AES slave
//   abort                                    - only when AES_SPI_MASTER_ABORT_EN is defined;
//                                              cancels a running frame without done
module aes_spi_master
  import aes_spi_pkg::*;
#(
  parameter int Nk       = 4,
  parameter int CLK_DIV  = 2,
  parameter int PAD_BITS = 2,
  parameter int GAP_BITS = 1,
  parameter int RX_SKIP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BLOCK_W-1:0]   data_in,
  input  logic [32*Nk-1:0]     key_in,
  output logic                 busy,
  output logic                 done,
  output logic [BLOCK_W-1:0]   data_out,
  output logic                 sck,
  output logic                 cs_n,
  output logic                 mosi,
  input  logic                 miso
`ifdef AES_SPI_MASTER_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  localparam int TX_W     = tx_bits(Nk, PAD_BITS);
  localparam int GAP_END  = gap_end(Nk, PAD_BITS, GAP_BITS);
  localparam int RX_START = rx_start(Nk, PAD_BITS, GAP_BITS, RX_SKIP);
  localparam int N_BITS   = frame_bits(Nk, PAD_BITS, GAP_BITS, RX_SKIP);
  localparam int CNT_W    = cnt_width(N_BITS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt;
  logic               trail_cnt;
  logic [TX_W-1:0]    tx_sr;
  logic [TX_W-1:0]    tx_load;
  logic [BLOCK_W-1:0] rx_sr;
  logic               tick, rise_tick, fall_tick;
  logic               start_acc, abort_now, rx_keep;

`ifdef AES_SPI_MASTER_ABORT_EN
  assign abort_now = abort && (state_q != IDLE);
`else
  assign abort_now = 1'b0;
`endif

  assign start_acc = (state_q == IDLE) && start;
  assign busy      = ~cs_n;
  // Zero-extension on the left supplies the leading pad bits.
  assign tx_load   = TX_W'({data_in, key_in});
  // bit_cnt holds rises completed so far; this rise is number bit_cnt+1.
  assign rx_keep   = rise_tick && (state_q == RX) && (bit_cnt >= CNT_W'(RX_START));

  aes_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .en        (~cs_n),
    .clr       (abort_now),
    .hold      (state_q == TRAIL),
    .tick      (tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sck       (sck)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // TRAIL spans two ticks: the low half of the final bit, then the trailing gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = LEAD;
      LEAD:  if (rise_tick) state_d = SHIFT;
      SHIFT: if (fall_tick && bit_cnt == CNT_W'(TX_W)) state_d = (GAP_BITS > 0) ? GAP : RX;
      GAP:   if (fall_tick && bit_cnt == CNT_W'(GAP_END)) state_d = RX;
      RX:    if (fall_tick && bit_cnt == CNT_W'(N_BITS)) state_d = TRAIL;
      TRAIL: if (tick && trail_cnt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_now) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
      bit_cnt   <= '0;
      trail_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_now) begin
        cs_n      <= 1'b1;
        mosi      <= 1'b0;
        bit_cnt   <= '0;
        trail_cnt <= 1'b0;
      end else if (start_acc) begin
        cs_n      <= 1'b0;
        mosi      <= tx_load[TX_W-1];
        bit_cnt   <= '0;
        trail_cnt <= 1'b0;
      end else begin
        if (rise_tick) bit_cnt <= bit_cnt + CNT_W'(1);
        // Zeros shift in behind the payload, so mosi is 0 through GAP and RX.
        if (fall_tick) mosi <= tx_sr[TX_W-1];
        if (state_q == TRAIL && tick) trail_cnt <= 1'b1;
        if (state_q == TRAIL && state_d == IDLE) begin
          cs_n     <= 1'b1;
          done     <= 1'b1;
          data_out <= rx_sr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_acc)      tx_sr <= tx_load << 1;
    else if (fall_tick) tx_sr <= tx_sr << 1;
    if (rx_keep) rx_sr <= {rx_sr[BLOCK_W-2:0], miso};
  end

endmodule
